// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline.
// Arbitrates memory freeze, branch mispredict and load-use hazards, and keeps perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_store,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       edest,
    input  logic             mwreg,
    input  logic [4:0]       mdest,
    input  logic             ebeq,
    input  logic             ebne,
    input  logic             ezero,
    input  logic             ebtaken,
    input  logic [31:0]      ebpc,
    input  logic [31:0]      epc4,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idexe_wen,
    output logic             idexe_bubble,
    output logic             exmem_wen,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ldst_depen,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    localparam int              WC_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MEM_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;

    logic freeze, br_actual, mispredict;
    logic hit_rs, hit_rt, load_stall;
    logic e_fwd_rs, m_fwd_rs, e_fwd_rt, m_fwd_rt;

    assign freeze     = dmem_req && !dmem_ready;
    assign br_actual  = (ebeq && ezero) || (ebne && !ezero);
    assign mispredict = (ebeq || ebne) && (br_actual != ebtaken);

    assign hit_rs     = id_use_rs && em2reg && ewreg && (edest != 5'd0) && (edest == id_rs);
    assign hit_rt     = id_use_rt && em2reg && ewreg && (edest != 5'd0) && (edest == id_rt);
    assign load_stall = hit_rs || (hit_rt && !id_is_store);

    // A load in EXE has no result yet, so only non-load EXE writers forward
    assign e_fwd_rs = ewreg && !em2reg && (edest != 5'd0) && (edest == id_rs);
    assign m_fwd_rs = mwreg && (mdest != 5'd0) && (mdest == id_rs);
    assign e_fwd_rt = ewreg && !em2reg && (edest != 5'd0) && (edest == id_rt);
    assign m_fwd_rt = mwreg && (mdest != 5'd0) && (mdest == id_rt);

    assign fwd_a = rst ? 2'b00 : (e_fwd_rs ? 2'b01 : (m_fwd_rs ? 2'b10 : 2'b00));
    assign fwd_b = rst ? 2'b00 : (e_fwd_rt ? 2'b01 : (m_fwd_rt ? 2'b10 : 2'b00));

    assign ldst_depen  = !rst && id_is_store && hit_rt && !hit_rs;
    assign redirect_pc = rst ? 32'd0 : (br_actual ? ebpc : epc4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_wen       = 1'b1;
        ifid_wen     = 1'b1;
        idexe_wen    = 1'b1;
        exmem_wen    = 1'b1;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        redirect     = 1'b0;

        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (freeze) begin
                    if (wait_cnt != WAIT_MAX)
                        wait_cnt_nxt = wait_cnt + WC_W'(1);
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        // Freeze holds everything, including an unresolved EXE branch
        if (rst) begin
            pc_wen       = 1'b0;
            ifid_wen     = 1'b0;
            idexe_wen    = 1'b0;
            exmem_wen    = 1'b0;
            idexe_bubble = 1'b1;
        end else if (freeze) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idexe_wen = 1'b0;
            exmem_wen = 1'b0;
        end else if (mispredict) begin
            redirect     = 1'b1;
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
        end else if (load_stall) begin
            pc_wen       = 1'b0;
            ifid_wen     = 1'b0;
            idexe_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (!pc_wen && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (wait_cnt_nxt == WAIT_MAX)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by a random run,
// all compared against a cycle-level reference model of the pipeline control rules.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 6;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, edest, mdest;
    logic             id_use_rs, id_use_rt, id_is_store;
    logic             ewreg, em2reg, mwreg;
    logic             ebeq, ebne, ezero, ebtaken;
    logic [31:0]      ebpc, epc4;
    logic             dmem_req, dmem_ready;
    logic             pc_wen, ifid_wen, ifid_flush, idexe_wen, idexe_bubble, exmem_wen;
    logic [1:0]       fwd_a, fwd_b;
    logic             ldst_depen, redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             err_timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_stall, m_flush, m_run;
    bit m_err;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_store(id_is_store), .ewreg(ewreg), .em2reg(em2reg), .edest(edest),
        .mwreg(mwreg), .mdest(mdest), .ebeq(ebeq), .ebne(ebne), .ezero(ezero),
        .ebtaken(ebtaken), .ebpc(ebpc), .epc4(epc4), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
        .ifid_flush(ifid_flush), .idexe_wen(idexe_wen), .idexe_bubble(idexe_bubble),
        .exmem_wen(exmem_wen), .fwd_a(fwd_a), .fwd_b(fwd_b), .ldst_depen(ldst_depen),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit loadDep(input logic [4:0] r);
        return em2reg && ewreg && (r != 5'd0) && (edest == r);
    endfunction

    function automatic logic [1:0] fwdSrc(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (ewreg && !em2reg && edest == r) return 2'b01;
        if (mwreg && mdest == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic modelReset();
        m_stall = 0;
        m_flush = 0;
        m_run   = 0;
        m_err   = 1'b0;
    endtask

    task automatic clearInputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_store = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0; edest = 5'd0; mwreg = 1'b0; mdest = 5'd0;
        ebeq = 1'b0; ebne = 1'b0; ezero = 1'b0; ebtaken = 1'b0;
        ebpc = 32'h0000_0040; epc4 = 32'h0000_0104;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Checks one cycle at the falling edge, then advances the model over the next rising edge
    task automatic applyStimulus(input string tag);
        bit frz, taken, mis, dep_rs, dep_rt, lu;
        bit e_pc, e_ifid, e_idexe, e_exmem, e_flush, e_bub, e_redir, e_ldst;
        logic [1:0] e_fa, e_fb;
        @(negedge clk);
        frz    = dmem_req && !dmem_ready;
        taken  = (ebeq && ezero) || (ebne && !ezero);
        mis    = (ebeq || ebne) && (taken != ebtaken);
        dep_rs = id_use_rs && loadDep(id_rs);
        dep_rt = id_use_rt && loadDep(id_rt);
        lu     = dep_rs || (dep_rt && !id_is_store);
        {e_pc, e_ifid, e_idexe, e_exmem} = 4'b1111;
        {e_flush, e_bub, e_redir} = 3'b000;
        if (rst) begin
            {e_pc, e_ifid, e_idexe, e_exmem} = 4'b0000;
            e_bub = 1'b1;
        end else if (frz) begin
            {e_pc, e_ifid, e_idexe, e_exmem} = 4'b0000;
        end else if (mis) begin
            {e_flush, e_bub, e_redir} = 3'b111;
        end else if (lu) begin
            {e_pc, e_ifid} = 2'b00;
            e_bub = 1'b1;
        end
        e_fa   = rst ? 2'b00 : fwdSrc(id_rs);
        e_fb   = rst ? 2'b00 : fwdSrc(id_rt);
        e_ldst = !rst && id_is_store && dep_rt && !dep_rs;

        checkOutput({tag, ".pc_wen"},       32'(pc_wen),       32'(e_pc));
        checkOutput({tag, ".ifid_wen"},     32'(ifid_wen),     32'(e_ifid));
        checkOutput({tag, ".idexe_wen"},    32'(idexe_wen),    32'(e_idexe));
        checkOutput({tag, ".exmem_wen"},    32'(exmem_wen),    32'(e_exmem));
        checkOutput({tag, ".ifid_flush"},   32'(ifid_flush),   32'(e_flush));
        checkOutput({tag, ".idexe_bubble"}, 32'(idexe_bubble), 32'(e_bub));
        checkOutput({tag, ".redirect"},     32'(redirect),     32'(e_redir));
        if (e_redir)
            checkOutput({tag, ".redirect_pc"}, redirect_pc, taken ? ebpc : epc4);
        checkOutput({tag, ".fwd_a"},        32'(fwd_a),        32'(e_fa));
        checkOutput({tag, ".fwd_b"},        32'(fwd_b),        32'(e_fb));
        checkOutput({tag, ".ldst_depen"},   32'(ldst_depen),   32'(e_ldst));
        checkOutput({tag, ".stall_cnt"},    32'(stall_cnt),    32'(sat(m_stall)));
        checkOutput({tag, ".flush_cnt"},    32'(flush_cnt),    32'(sat(m_flush)));
        checkOutput({tag, ".err_timeout"},  32'(err_timeout),  32'(m_err));

        if (!rst) begin
            if (!e_pc) m_stall++;
            if (e_redir) m_flush++;
            m_run = frz ? m_run + 1 : 0;
            if (m_run >= MEM_TIMEOUT) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        modelReset();
        clearInputs();
        rst = 1'b1;
        #1;
        applyStimulus("reset");
        checkOutput("reset.bubble_const", 32'(idexe_bubble), 32'd1);
        rst = 1'b0;

        // Independent adds: EXE/MEM write unrelated registers
        for (int i = 0; i < 3; i++) begin
            id_rs = 5'(4 + i); id_rt = 5'(5 + i); id_use_rs = 1'b1; id_use_rt = 1'b1;
            ewreg = 1'b1; edest = 5'(10 + i); mwreg = 1'b1; mdest = 5'(20 + i);
            applyStimulus("indep");
        end
        checkOutput("indep.stall_zero", 32'(stall_cnt), 32'd0);

        // lw $2 in EXE, add reading $2 -> one stall, then MEM forward
        clearInputs();
        ewreg = 1'b1; em2reg = 1'b1; edest = 5'd2;
        id_rs = 5'd2; id_rt = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b1;
        applyStimulus("lu_stall");
        checkOutput("lu.stall_cnt_one", 32'(stall_cnt), 32'd1);
        ewreg = 1'b0; em2reg = 1'b0; edest = 5'd0; mwreg = 1'b1; mdest = 5'd2;
        applyStimulus("lu_after");

        // sw with rt hit -> no stall; sw with rs hit -> stall
        clearInputs();
        ewreg = 1'b1; em2reg = 1'b1; edest = 5'd2;
        id_is_store = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1; id_rs = 5'd7; id_rt = 5'd2;
        applyStimulus("sw_rt");
        id_rs = 5'd2; id_rt = 5'd7;
        applyStimulus("sw_rs");
        // register 0 never hazards
        edest = 5'd0; id_rs = 5'd0; id_rt = 5'd0; em2reg = 1'b0;
        applyStimulus("r0");

        // Mispredicts
        clearInputs();
        ebeq = 1'b1; ezero = 1'b1; ebtaken = 1'b0; ebpc = 32'h40;
        applyStimulus("beq_mis");
        checkOutput("beq.pc_const", redirect_pc, 32'h40);
        ebeq = 1'b0; ebne = 1'b1; ezero = 1'b1; ebtaken = 1'b1; epc4 = 32'h0000_0208;
        applyStimulus("bne_mis");
        // Mispredict overrides a coincident load-use stall
        ewreg = 1'b1; em2reg = 1'b1; edest = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
        applyStimulus("mis_over_lu");

        // Freeze holds the mispredict until dmem_ready
        clearInputs();
        ebeq = 1'b1; ezero = 1'b1; ebtaken = 1'b0; ebpc = 32'h80;
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("frz_hold");
        dmem_ready = 1'b1;
        applyStimulus("frz_release");
        clearInputs();
        applyStimulus("frz_after");

        // Timeout: err sets after MEM_TIMEOUT frozen cycles and sticks
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) applyStimulus("timeout");
        checkOutput("timeout.err_const", 32'(err_timeout), 32'd1);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_mid.stall_cnt", 32'(stall_cnt), 32'd0);
        applyStimulus("rst_mid");
        rst = 1'b0;
        dmem_req = 1'b0;
        applyStimulus("post_rst");

        // Random traffic with a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (rst) modelReset();
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            edest = 5'($urandom_range(0, 3)); mdest = 5'($urandom_range(0, 3));
            {id_use_rs, id_use_rt, id_is_store} = 3'($urandom);
            {ewreg, em2reg, mwreg, ezero, ebtaken} = 5'($urandom);
            ebeq = ($urandom_range(0, 3) == 0);
            ebne = !ebeq && ($urandom_range(0, 3) == 0);
            ebpc = $urandom; epc4 = $urandom;
            if (!(dmem_req && !dmem_ready)) dmem_req = ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, 2) == 0);
            applyStimulus("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
